// File: rtl/mul_pkg.sv
// Shared definitions for the Booth/Wallace multiplier:
// operation codes and Booth digit selects.
package mul_pkg;

    localparam logic [1:0] MUL_OP_LO = 2'b00;
    localparam logic [1:0] MUL_OP_H  = 2'b01;
    localparam logic [1:0] MUL_OP_HU = 2'b10;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_sel_e;

    // Radix-4 recoding of {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_sel_e booth_sel(input logic [2:0] g);
        case (g)
            3'b001, 3'b010: return POS1;
            3'b011:         return POS2;
            3'b100:         return NEG2;
            3'b101, 3'b110: return NEG1;
            default:        return ZERO;
        endcase
    endfunction

    function automatic logic booth_neg(input booth_sel_e s);
        return (s == NEG1) || (s == NEG2);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit 3:2 compressor cell.
// Building block of the Wallace columns.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/wallace_column.sv
// One product column of the Wallace tree.
// Full adders consume bits oldest-first until one sum/carry pair is left.
module wallace_column #(
    parameter int N_IN  = 17,
    parameter int N_CIN = N_IN - 3
) (
    input  logic [N_IN-1:0]  in,
    input  logic [N_CIN-1:0] cin,
    output logic [N_CIN-1:0] cout,
    output logic             S,
    output logic             C
);

    // Column bits first, then carries arriving from the column below.
    localparam int T = N_IN + N_CIN;
    // Every adder but the last sends its carry to the next column.
    localparam int K = N_CIN + 1;

    logic [T-1:0] base;

    assign base = {cin, in};

    // Pool slot p < T is an original bit; slot T+k is the sum of adder k.
    for (genvar k = 0; k < K; k++) begin : g_fa
        logic [2:0] x;
        logic       s;
        logic       c;

        for (genvar m = 0; m < 3; m++) begin : g_x
            if (3 * k + m < T) begin : g_base
                assign x[m] = base[3*k+m];
            end else begin : g_sum
                assign x[m] = g_fa[3*k+m-T].s;
            end
        end

        full_adder u_fa (
            .a (x[0]),
            .b (x[1]),
            .ci(x[2]),
            .s (s),
            .co(c)
        );
    end

    for (genvar k = 0; k < N_CIN; k++) begin : g_co
        assign cout[k] = g_fa[k].c;
    end

    assign S = g_fa[K-1].s;
    assign C = g_fa[K-1].c;

endmodule

// File: rtl/booth_wallace_mul.sv
// Pipelined radix-4 Booth / Wallace-tree multiplier with
// valid/ready handshake, flush and low/high result select.
module booth_wallace_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int PP_NUM = WIDTH / 2 + 1;
    localparam int PW     = 2 * WIDTH;
    // One extra slot per column carries the negation +1 of row j/2.
    localparam int N_IN   = PP_NUM + 1;
    localparam int N_CIN  = N_IN - 3;

    // Selected multiple, sign-extended across the full product width.
    function automatic logic [PW-1:0] pp_row(
        input booth_sel_e       sel,
        input logic [WIDTH+1:0] m1,
        input logic [WIDTH+1:0] m2
    );
        logic [WIDTH+1:0] r;
        case (sel)
            POS1:    r = m1;
            POS2:    r = m2;
            NEG1:    r = ~m1;
            NEG2:    r = ~m2;
            default: r = '0;
        endcase
        return {{(PW - WIDTH - 2){r[WIDTH+1]}}, r};
    endfunction

    logic             sx;
    logic [WIDTH+1:0] a_ext;
    logic [WIDTH+1:0] a_dbl;
    logic [WIDTH+2:0] b_pad;

    booth_sel_e        sel [PP_NUM];
    logic [PW-1:0]     pp  [PP_NUM];
    logic [PP_NUM-1:0] neg;
    logic [N_IN-1:0]   col_in [PW];

    logic [PW-1:0]    sum_w;
    logic [PW-1:0]    carry_w;
    logic [N_CIN-1:0] unused_cout;
    logic             unused_c;

    logic             s1_valid_q, s1_valid_d;
    logic [PW-1:0]    s1_sum_q;
    logic [PW-1:0]    s1_carry_q;
    logic [1:0]       s1_op_q;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             s2_free;
    logic             advance;
    logic             accept;
    logic             hi_sel;
    logic [PW-1:0]    prod;

    // Unsigned high multiply zero-extends; every other op sign-extends.
    assign sx    = (op != MUL_OP_HU);
    assign a_ext = {{2{sx & a[WIDTH-1]}}, a};
    assign a_dbl = {a_ext[WIDTH:0], 1'b0};
    assign b_pad = {{2{sx & b[WIDTH-1]}}, b, 1'b0};

    for (genvar i = 0; i < PP_NUM; i++) begin : g_booth
        assign sel[i] = booth_sel(b_pad[2*i +: 3]);
        assign pp[i]  = pp_row(sel[i], a_ext, a_dbl);
        assign neg[i] = booth_neg(sel[i]);
    end

    for (genvar j = 0; j < PW; j++) begin : g_cin
        for (genvar i = 0; i < PP_NUM; i++) begin : g_pp
            if (j >= 2 * i) begin : g_on
                assign col_in[j][i] = pp[i][j-2*i];
            end else begin : g_off
                assign col_in[j][i] = 1'b0;
            end
        end
        if ((j % 2 == 0) && (j / 2 < PP_NUM)) begin : g_neg
            assign col_in[j][PP_NUM] = neg[j/2];
        end else begin : g_noneg
            assign col_in[j][PP_NUM] = 1'b0;
        end
    end

    for (genvar j = 0; j < PW; j++) begin : g_col
        logic [N_CIN-1:0] cin;
        logic [N_CIN-1:0] cout;
        logic             s;
        logic             c;

        if (j == 0) begin : g_first
            assign cin = '0;
        end else begin : g_next
            assign cin = g_col[j-1].cout;
        end

        wallace_column #(
            .N_IN (N_IN),
            .N_CIN(N_CIN)
        ) u_col (
            .in  (col_in[j]),
            .cin (cin),
            .cout(cout),
            .S   (s),
            .C   (c)
        );

        assign sum_w[j] = s;
        if (j < PW - 1) begin : g_cy
            assign carry_w[j+1] = c;
        end
    end

    // Carries out of the top column fall outside the 2*WIDTH product.
    assign carry_w[0]  = 1'b0;
    assign unused_cout = g_col[PW-1].cout;
    assign unused_c    = g_col[PW-1].c;

    assign s2_free  = !out_valid_q || out_ready;
    assign advance  = s1_valid_q && s2_free;
    assign in_ready = resetn && !flush && (!s1_valid_q || s2_free);
    assign accept   = in_valid && in_ready;

    assign prod   = s1_sum_q + s1_carry_q;
    assign hi_sel = (s1_op_q == MUL_OP_H) || (s1_op_q == MUL_OP_HU);

    // Next-state for both stages; flush drops everything in flight.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        if (advance) begin
            out_valid_d = 1'b1;
            result_d    = hi_sel ? prod[PW-1:WIDTH] : prod[WIDTH-1:0];
        end else if (s2_free) begin
            out_valid_d = 1'b0;
        end
        if (advance) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
        end
        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    // Stage 1: capture the reduced sum/carry pair on accept.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_carry_q <= '0;
            s1_op_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_sum_q   <= sum_w;
                s1_carry_q <= carry_w;
                s1_op_q    <= op;
            end
        end
    end

    // Stage 2: final add result, held under backpressure.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_booth_wallace_mul.sv
// Self-checking bench for booth_wallace_mul (WIDTH 32 and 8 side by side)
// against an arithmetic reference model with an in-flight queue.
module tb_booth_wallace_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn    = 1'b0;
    logic        in_valid  = 1'b0;
    logic        flush     = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a         = '0;
    logic [31:0] b         = '0;
    logic [1:0]  op        = '0;

    logic        in_ready, out_valid;
    logic [31:0] result;
    logic        in_ready8, out_valid8;
    logic [7:0]  result8;

    booth_wallace_mul #(.WIDTH(32)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result)
    );

    booth_wallace_mul #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready8),
        .a        (a[7:0]),
        .b        (b[7:0]),
        .op       (op),
        .flush    (flush),
        .out_valid(out_valid8),
        .out_ready(out_ready),
        .result   (result8)
    );

    typedef struct {
        logic [31:0] e32;
        logic [7:0]  e8;
        int          t;
    } item_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    item_t       q[$];
    logic [31:0] fired[$];
    int          fire_cyc[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Product of w-bit operands modulo 2^(2w), then the requested half.
    function automatic logic [63:0] ref_mul(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [1:0] o,
                                            input int w);
        logic [63:0] m, ex, ey, p;
        m  = (64'd1 << w) - 64'd1;
        ex = {32'd0, x} & m;
        ey = {32'd0, y} & m;
        if (o != 2'b10) begin
            if (ex[w-1]) ex = ex | ~m;
            if (ey[w-1]) ey = ey | ~m;
        end
        p = ex * ey;
        if (o == 2'b01 || o == 2'b10) return (p >> w) & m;
        return p & m;
    endfunction

    // Compare process: everything accepted is owed back, in order, after 2 edges.
    always @(negedge clk) begin
        logic        exp_v, exp_r;
        logic [63:0] r32, r8;
        item_t       it;
        exp_v = (q.size() > 0) && (cyc >= q[0].t + 2);
        exp_r = resetn && !flush && (q.size() < 2 || out_ready);
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
        chk("out_valid8", {63'd0, out_valid8}, {63'd0, exp_v});
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_r});
        chk("in_ready8", {63'd0, in_ready8}, {63'd0, exp_r});
        if (exp_v && out_valid) begin
            chk("result", {32'd0, result}, {32'd0, q[0].e32});
            chk("result8", {56'd0, result8}, {56'd0, q[0].e8});
            if (out_ready) begin
                fired.push_back(result);
                fire_cyc.push_back(cyc);
                void'(q.pop_front());
            end
        end
        if (in_valid && in_ready) begin
            r32    = ref_mul(a, b, op, 32);
            r8     = ref_mul(a, b, op, 8);
            it.e32 = r32[31:0];
            it.e8  = r8[7:0];
            it.t   = cyc;
            q.push_back(it);
        end
        if (flush || !resetn) q.delete();
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y,
                         input logic [1:0] o, input bit want_ready);
        bit got;
        got      = 1'b0;
        a        = x;
        b        = y;
        op       = o;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
            if (want_ready) chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
            tick();
        end
        if (!got) chk("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 200 && q.size() > 0; k++) tick();
        chk("drain_empty", 64'(q.size()), 64'd0);
        tick();
    endtask

    task automatic expect_fired(input string name, input int n,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e = '{e0, e1, e2, e3};
        chk({name, "_count"}, 64'(fired.size()), 64'(n));
        for (int k = 0; k < n && k < fired.size(); k++)
            chk(name, {32'd0, fired[k]}, {32'd0, e[k]});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return {$urandom_range(0, 32'hFFFFFF), 8'h80};
            5:       return {$urandom_range(0, 32'hFFFFFF), 8'h7F};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        chk("model_m1_lo", ref_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32), 64'h1);
        chk("model_m1_h", ref_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32), 64'h0);
        chk("model_m1_hu", ref_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32), 64'hFFFFFFFE);
        chk("model_min_h", ref_mul(32'h80000000, 32'h80000000, 2'b01, 32), 64'h40000000);
        chk("model_neg_lo", ref_mul(32'd7, 32'hFFFFFFFE, 2'b11, 32), 64'hFFFFFFF2);
        chk("model_w8_hu", ref_mul(32'h80, 32'h80, 2'b10, 8), 64'h40);
        chk("model_w8_h", ref_mul(32'hFF, 32'hFF, 2'b01, 8), 64'h0);
        chk("model_w8_hu2", ref_mul(32'hFF, 32'hFF, 2'b10, 8), 64'hFE);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_result", {32'd0, result}, 64'd0);
        chk("reset_result8", {56'd0, result8}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        resetn    = 1'b1;
        out_ready = 1'b1;
        tick();

        fired.delete();
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 1'b1);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 1'b1);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 1'b1);
        drain();
        expect_fired("all_ones", 3, 32'h1, 32'h0, 32'hFFFFFFFE, 32'h0);

        fired.delete();
        issue(32'h80000000, 32'h80000000, 2'b01, 1'b1);
        issue(32'h80000000, 32'h80000000, 2'b00, 1'b1);
        issue(32'h80000000, 32'h80000000, 2'b10, 1'b1);
        drain();
        expect_fired("min_int", 3, 32'h40000000, 32'h0, 32'h40000000, 32'h0);

        fired.delete();
        fire_cyc.delete();
        issue(32'd3, 32'd5, 2'b00, 1'b1);
        issue(32'd7, 32'hFFFFFFFE, 2'b00, 1'b1);
        issue(32'd0, 32'h1234, 2'b00, 1'b1);
        issue(32'h7FFFFFFF, 32'd2, 2'b00, 1'b1);
        drain();
        expect_fired("b2b", 4, 32'd15, 32'hFFFFFFF2, 32'd0, 32'hFFFFFFFE);
        for (int k = 1; k < 4 && k < fire_cyc.size(); k++)
            chk("b2b_consecutive", 64'(fire_cyc[k] - fire_cyc[0]), 64'(k));

        fired.delete();
        out_ready = 1'b0;
        issue(32'd2, 32'd3, 2'b00, 1'b0);
        issue(32'd4, 32'd5, 2'b00, 1'b0);
        a        = 32'd6;
        b        = 32'd7;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_hold", {32'd0, result}, 64'd6);
            tick();
        end
        out_ready = 1'b1;
        issue(32'd6, 32'd7, 2'b00, 1'b0);
        drain();
        expect_fired("stall", 3, 32'd6, 32'd20, 32'd42, 32'h0);

        fired.delete();
        out_ready = 1'b0;
        issue(32'd11, 32'd13, 2'b00, 1'b0);
        issue(32'd17, 32'd19, 2'b00, 1'b0);
        a        = 32'd5;
        b        = 32'd5;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_ready_after", {63'd0, in_ready}, 64'd1);
        tick();
        out_ready = 1'b1;
        repeat (4) tick();
        chk("flush_no_output", 64'(fired.size()), 64'd0);

        out_ready = 1'b0;
        issue(32'd11, 32'd13, 2'b00, 1'b0);
        issue(32'd17, 32'd19, 2'b01, 1'b0);
        in_valid = 1'b1;
        resetn   = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        resetn   = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_result8", {56'd0, result8}, 64'd0);
        tick();
        out_ready = 1'b1;
        repeat (4) tick();
        chk("rst_no_output", 64'(fired.size()), 64'd0);

        for (int k = 0; k < 10000; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            a         = pick();
            b         = pick();
            op        = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 199) == 0);
            tick();
        end
        flush = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
